// File: rtl/goomba_pkg.sv
// -----------------------------------------------------------------------------
// goomba_pkg
// Shared constants and the state encoding for the goomba motion sequencer.
// The goomba renderer uses the same state encoding.
//   WIDTH/HEIGHT      : goomba sprite size in px
//   SCREEN_W          : visible screen width in px
//   REAL_GROUND       : y of the real floor surface
//   X_MAX, FLOOR_Y    : derived clamps for goomba_x / goomba_y
//   CNT_W             : width of the frame-tick divider counters
// -----------------------------------------------------------------------------
package goomba_pkg;

  localparam int unsigned WIDTH       = 26;
  localparam int unsigned HEIGHT      = 27;
  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned REAL_GROUND = 440;

  // Rightmost legal left edge and the top edge when standing on the real floor.
  localparam logic [9:0] X_MAX   = 10'(SCREEN_W - 1 - WIDTH);
  localparam logic [9:0] FLOOR_Y = 10'(REAL_GROUND - HEIGHT);

  // Wide enough for both the walk divider and the squash frame count.
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    ST_WALK    = 2'd0,
    ST_FALL    = 2'd1,
    ST_SQUASH  = 2'd2,
    ST_RESPAWN = 2'd3
  } goomba_state_e;

endpackage

// File: rtl/goomba_if.sv
// -----------------------------------------------------------------------------
// goomba_if
// Bundle between the goomba motion sequencer and its environment.
//   frame_tick   : one-cycle pulse per video frame
//   ground       : goomba bottom exactly on a platform top (combinational)
//   stomp        : one-cycle pulse, Mario landed on the goomba
//   goomba_x/y   : left / top edge in px
//   goomba_dir   : 1 = right, 0 = left
//   goomba_state : WALK/FALL/SQUASH/RESPAWN
//   goomba_alive : high in WALK/FALL
// Modports: master = the sequencer, slave = the environment driving it.
// -----------------------------------------------------------------------------
interface goomba_if;
  import goomba_pkg::*;

  logic          frame_tick;
  logic          ground;
  logic          stomp;
  logic [9:0]    goomba_x;
  logic [9:0]    goomba_y;
  logic          goomba_dir;
  goomba_state_e goomba_state;
  logic          goomba_alive;

  modport master (
    input  frame_tick, ground, stomp,
    output goomba_x, goomba_y, goomba_dir, goomba_state, goomba_alive
  );

  modport slave (
    output frame_tick, ground, stomp,
    input  goomba_x, goomba_y, goomba_dir, goomba_state, goomba_alive
  );

endinterface

// File: rtl/goomba_tick_div.sv
// -----------------------------------------------------------------------------
// goomba_tick_div
// Frame-tick gated modulo counter. Counts 0..modulus-1 on each tick and
// flags the tick on which it wraps.
//   clk, rst : clock, synchronous active-high reset
//   tick     : advance enable
//   clear    : force the count to zero (wins over tick)
//   modulus  : wrap length, >= 1, may change while counting
//   wrap     : combinational, high on the tick that returns the count to 0
// -----------------------------------------------------------------------------
module goomba_tick_div
  import goomba_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear,
  input  logic [CNT_W-1:0] modulus,
  output logic             wrap
);

  logic [CNT_W-1:0] count_q, count_d;

  // >= rather than == so a modulus that shrinks under the current count
  // still wraps instead of running all the way round.
  assign wrap = tick && (count_q >= modulus - CNT_W'(1));

  always_comb begin
    // NOTE: default assignment first so no path leaves count_d unassigned,
    // which would otherwise infer a latch.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = wrap ? '0 : count_q + CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/goomba_motion.sv
// -----------------------------------------------------------------------------
// goomba_motion
// Goomba position/state sequencer: walks, falls off bar edges, bounces at the
// screen edges, exits through the bottom-floor edges into the top pipes, and
// is squashed and respawned when stomped. All outputs are registered.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : goomba_if.master (frame_tick/ground/stomp in, position/state out)
// Build option: define GOOMBA_SPEEDUP_EN to make the walk divider a live
// register that drops by one (floor 1) on every squash respawn.
// -----------------------------------------------------------------------------
module goomba_motion
  import goomba_pkg::*;
#(
  parameter logic [9:0]       SPAWN_L_X     = 10'd40,
  parameter logic [9:0]       SPAWN_R_X     = 10'd582,
  parameter logic [9:0]       SPAWN_Y       = 10'd35,
  parameter logic [CNT_W-1:0] WALK_DIV      = CNT_W'(2),
  parameter logic [CNT_W-1:0] SQUASH_FRAMES = CNT_W'(30)
) (
  input  logic     clk,
  input  logic     rst,
  goomba_if.master bus
);

  goomba_state_e    state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             dir_q, dir_d, alive_q, alive_d;
  // Which pipe the next respawn uses: 1 = left pipe (after a right exit).
  logic             spawn_left_q, spawn_left_d;

  logic             stomp_take;
  logic             walk_tick, walk_clr, walk_wrap;
  logic             squash_tick, squash_wrap;
  logic [CNT_W-1:0] walk_div;

  // A stomp is only honoured while the goomba is alive and beats frame_tick.
  assign stomp_take  = bus.stomp && (state_q == ST_WALK || state_q == ST_FALL);
  assign walk_tick   = bus.frame_tick && !stomp_take && state_q == ST_WALK && bus.ground;
  assign walk_clr    = bus.frame_tick && !stomp_take && state_q == ST_FALL &&
                       (bus.ground || y_q >= FLOOR_Y);
  assign squash_tick = bus.frame_tick && state_q == ST_SQUASH;

  goomba_tick_div u_walk_div (
    .clk     (clk),
    .rst     (rst),
    .tick    (walk_tick),
    .clear   (walk_clr),
    .modulus (walk_div),
    .wrap    (walk_wrap)
  );

  goomba_tick_div u_squash_div (
    .clk     (clk),
    .rst     (rst),
    .tick    (squash_tick),
    .clear   (stomp_take),
    .modulus (SQUASH_FRAMES),
    .wrap    (squash_wrap)
  );

`ifdef GOOMBA_SPEEDUP_EN
  logic [CNT_W-1:0] walk_div_q, walk_div_d;

  // squash_wrap is exactly the SQUASH -> RESPAWN transition.
  always_comb begin
    walk_div_d = walk_div_q;
    if (squash_wrap && walk_div_q > CNT_W'(1)) walk_div_d = walk_div_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) walk_div_q <= WALK_DIV;
    else     walk_div_q <= walk_div_d;
  end

  assign walk_div = walk_div_q;
`else
  assign walk_div = WALK_DIV;
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_d        = dir_q;
    spawn_left_d = spawn_left_q;

    if (stomp_take) begin
      state_d      = ST_SQUASH;
      spawn_left_d = 1'b0;
    end else if (bus.frame_tick) begin
      case (state_q)
        ST_WALK: begin
          if (!bus.ground) begin
            state_d = ST_FALL;
          end else if (walk_wrap) begin
            if (dir_q && x_q < X_MAX)        x_d = x_q + 10'd1;
            else if (!dir_q && x_q != 10'd0) x_d = x_q - 10'd1;
            else if (y_q != FLOOR_Y)         dir_d = !dir_q;
            else begin
              // Bottom-floor edge: leave through the pipe on this side.
              state_d      = ST_RESPAWN;
              spawn_left_d = dir_q;
            end
          end
        end
        ST_FALL: begin
          // 1 px steps keep the equality-based ground detect from being skipped.
          if (bus.ground || y_q >= FLOOR_Y) state_d = ST_WALK;
          else                              y_d = y_q + 10'd1;
        end
        ST_SQUASH: begin
          if (squash_wrap) state_d = ST_RESPAWN;
        end
        ST_RESPAWN: begin
          y_d     = SPAWN_Y;
          x_d     = spawn_left_q ? SPAWN_L_X : SPAWN_R_X;
          dir_d   = spawn_left_q;
          state_d = ST_FALL;
        end
        default: ;
      endcase
    end

    alive_d = (state_d == ST_WALK) || (state_d == ST_FALL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_WALK;
      x_q          <= SPAWN_L_X;
      y_q          <= SPAWN_Y;
      dir_q        <= 1'b1;
      alive_q      <= 1'b1;
      spawn_left_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
      alive_q      <= alive_d;
      spawn_left_q <= spawn_left_d;
    end
  end

  assign bus.goomba_x     = x_q;
  assign bus.goomba_y     = y_q;
  assign bus.goomba_dir   = dir_q;
  assign bus.goomba_state = state_q;
  assign bus.goomba_alive = alive_q;

endmodule

// File: tb/tb_goomba_motion.sv
// -----------------------------------------------------------------------------
// tb_goomba_motion
// Directed bench for goomba_motion: a vector table for walk/fall/squash entry
// followed by hand-written sequences for squash timing, reset mid-squash,
// floor exits on both sides and the mid-screen bounce.
// -----------------------------------------------------------------------------
module tb_goomba_motion;

  localparam int WALK = 0, FALL = 1, SQUASH = 2, RESPAWN = 3;
`ifdef GOOMBA_SPEEDUP_EN
  localparam int STEPS4 = 4;  // steps per 4 ticks once the divider is 1
`else
  localparam int STEPS4 = 2;  // WALK_DIV = 2
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  goomba_if bus ();

  goomba_motion dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic g, s, t;
    int   x, y, dir, st, alive;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_out(input string tag, input int x, input int y,
                           input int dir, input int st, input int alive);
    check({tag, " x"},     int'(bus.goomba_x),     x);
    check({tag, " y"},     int'(bus.goomba_y),     y);
    check({tag, " dir"},   int'(bus.goomba_dir),   dir);
    check({tag, " state"}, int'(bus.goomba_state), st);
    check({tag, " alive"}, int'(bus.goomba_alive), alive);
  endtask

  // One frame_tick per cycle for n cycles; returns at a falling edge.
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      @(negedge clk);
    end
    bus.frame_tick = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            g  s  t    x   y  dir st       alive
    tbl[0]  = '{1, 0, 0,  40, 35, 1, WALK,    1};
    tbl[1]  = '{1, 0, 1,  40, 35, 1, WALK,    1};
    tbl[2]  = '{1, 0, 1,  41, 35, 1, WALK,    1};
    tbl[3]  = '{1, 0, 1,  41, 35, 1, WALK,    1};
    tbl[4]  = '{0, 0, 1,  41, 35, 1, FALL,    1};  // walk count left at 1
    tbl[5]  = '{0, 0, 0,  41, 35, 1, FALL,    1};
    tbl[6]  = '{0, 0, 1,  41, 36, 1, FALL,    1};
    tbl[7]  = '{0, 0, 1,  41, 37, 1, FALL,    1};
    tbl[8]  = '{1, 0, 1,  41, 37, 1, WALK,    1};  // land, walk count cleared
    tbl[9]  = '{1, 0, 1,  41, 37, 1, WALK,    1};
    tbl[10] = '{1, 0, 1,  42, 37, 1, WALK,    1};
    tbl[11] = '{1, 1, 1,  42, 37, 1, SQUASH,  0};  // stomp beats tick
    tbl[12] = '{1, 1, 1,  42, 37, 1, SQUASH,  0};  // repeat stomp ignored
    tbl[13] = '{0, 1, 0,  42, 37, 1, SQUASH,  0};

    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.ground = 1'b1;
    bus.stomp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_out("reset", 40, 35, 1, WALK, 1);

    for (int i = 0; i < 14; i++) begin
      bus.ground     = tbl[i].g;
      bus.stomp      = tbl[i].s;
      bus.frame_tick = tbl[i].t;
      @(negedge clk);
      check_out($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].dir,
                tbl[i].st, tbl[i].alive);
    end
    bus.stomp = 1'b0;
    bus.frame_tick = 1'b0;
    bus.ground = 1'b1;

    // One SQUASH tick already counted in vec12; 28 more stay in SQUASH.
    do_ticks(28);
    check_out("squash29", 42, 37, 1, SQUASH, 0);
    do_ticks(1);
    check_out("squash_exit", 42, 37, 1, RESPAWN, 0);
    do_ticks(1);
    check_out("respawn_sq", 582, 35, 0, FALL, 1);
    do_ticks(1);
    check_out("land_sq", 582, 35, 0, WALK, 1);
    do_ticks(4);
    check("walk_rate0 x", int'(bus.goomba_x), 582 - STEPS4);

    // Two more squash/respawn rounds; the divider floors at 1 when live.
    for (int r = 1; r <= 2; r++) begin
      bus.stomp = 1'b1;
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.stomp = 1'b0;
      bus.frame_tick = 1'b0;
      check_out($sformatf("sq%0d", r), 582 - STEPS4, 35, 0, SQUASH, 0);
      do_ticks(30);
      check($sformatf("sq%0d_exit state", r), int'(bus.goomba_state), RESPAWN);
      do_ticks(1);
      check_out($sformatf("sq%0d_spawn", r), 582, 35, 0, FALL, 1);
      do_ticks(1);
      do_ticks(4);
      check($sformatf("walk_rate%0d x", r), int'(bus.goomba_x), 582 - STEPS4);
    end

    // Reset in the middle of a squash.
    bus.stomp = 1'b1;
    @(negedge clk);
    bus.stomp = 1'b0;
    check("sq_mid state", int'(bus.goomba_state), SQUASH);
    do_ticks(5);
    pulse_reset();
    check_out("rst_mid_sq", 40, 35, 1, WALK, 1);
    do_ticks(1);
    check("rst_walk1 x", int'(bus.goomba_x), 40);
    do_ticks(1);
    check("rst_walk2 x", int'(bus.goomba_x), 41);

    // Fall to the real floor, walk to the right edge and exit.
    pulse_reset();
    bus.ground = 1'b0;
    do_ticks(1);
    check_out("a_fall", 40, 35, 1, FALL, 1);
    do_ticks(378);
    check_out("a_floor", 40, 413, 1, FALL, 1);
    do_ticks(1);
    check_out("a_clamp", 40, 413, 1, WALK, 1);
    bus.ground = 1'b1;
    do_ticks(1146);
    check_out("a_right", 613, 413, 1, WALK, 1);
    do_ticks(2);
    check_out("a_exit", 613, 413, 1, RESPAWN, 0);
    do_ticks(1);
    check_out("a_spawn", 40, 35, 1, FALL, 1);
    do_ticks(1);
    check("a_land state", int'(bus.goomba_state), WALK);

    // Mid-screen bounce at the right edge.
    bus.ground = 1'b0;
    do_ticks(77);
    check_out("b_mid", 40, 111, 1, FALL, 1);
    bus.ground = 1'b1;
    do_ticks(1);
    do_ticks(1146);
    check_out("b_edge", 613, 111, 1, WALK, 1);
    do_ticks(2);
    check_out("b_bounce", 613, 111, 0, WALK, 1);
    do_ticks(2);
    check_out("b_back", 612, 111, 0, WALK, 1);

    // Drop to the floor, walk to the left edge and exit to the right pipe.
    bus.ground = 1'b0;
    do_ticks(303);
    check_out("c_floor", 612, 413, 0, FALL, 1);
    do_ticks(1);
    check("c_clamp state", int'(bus.goomba_state), WALK);
    bus.ground = 1'b1;
    do_ticks(1224);
    check_out("c_left", 0, 413, 0, WALK, 1);
    do_ticks(2);
    check_out("c_exit", 0, 413, 0, RESPAWN, 0);
    do_ticks(1);
    check_out("c_spawn", 582, 35, 0, FALL, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
